regfile_sb: RTL and testbench

Architectural integer register file plus per-register write scoreboard. It sits at the receiving end of the writeback interface and consumes the `writeback_data_t` bundle the writeback stage emits each cycle. It serves two combinational read ports to decode and tracks in-flight writers so decode can stall on RAW hazards. x0 is hardwired to zero.

---
 rtl/regfile_sb_pkg.sv | 15 +
 rtl/regfile_sb_counter.sv | 25 ++
 rtl/regfile_sb.sv | 87 ++++++++
 tb/tb_regfile_sb.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared word/address types and the writeback bundle consumed by regfile_sb
package common;
  typedef logic [63:0] word_t;
  typedef logic [4:0]  creg_addr_t;
  localparam int NREG = 32;
endpackage

package pipes;
  import common::*;
  typedef struct packed {
    logic       regwrite;
    creg_addr_t dst;
    word_t      regdata;
  } writeback_data_t;
endpackage

// File: rtl/regfile_sb_counter.sv
// sb_counter: saturating up/down in-flight writer counter for one register
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         sat
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt = cnt_q;
  assign sat = &cnt_q;
  // simultaneous inc and dec cancel; never wrap past max or below zero
  always_comb
    cnt_d = (inc && !dec && !sat) ? cnt_q + W'(1) :
            (dec && !inc && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // a writeback retiring a writer that was never issued is an upstream bug
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(dec && cnt_q == '0));
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with RAW scoreboard; define REGFILE_BYPASS_EN for same-cycle writeback forwarding
module regfile_sb
  import pipes::*;
#(
  parameter int NREG  = common::NREG,
  parameter int CNT_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  writeback_data_t    dataW,
  input  common::creg_addr_t ra1,
  input  common::creg_addr_t ra2,
  output common::word_t      rd1,
  output common::word_t      rd2,
  output logic               busy1,
  output logic               busy2,
  input  logic               issue_valid,
  input  logic               issue_regwrite,
  input  common::creg_addr_t issue_dst,
  output logic               issue_ready
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  common::word_t    regs_q [1:NREG-1];
  common::word_t    regs_d [1:NREG-1];
  logic [CNT_W-1:0] cnt    [1:NREG-1];
  logic             sat    [1:NREG-1];
  logic             wb_en, byp1, byp2;
  assign wb_en = dataW.regwrite && dataW.dst != '0;
  assign byp1  = BYPASS && wb_en && dataW.dst == ra1;
  assign byp2  = BYPASS && wb_en && dataW.dst == ra2;
  // single writeback port; x0 has no storage so its writes fall away
  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < NREG; r++)
      if (wb_en && dataW.dst == 5'(r)) regs_d[r] = dataW.regdata;
  end
  // register storage, cleared asynchronously
  always_ff @(posedge clk or posedge reset)
    if (reset) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  for (genvar r = 1; r < NREG; r++) begin : g_sb
    logic inc, dec;
    assign inc = issue_valid && issue_regwrite && issue_dst == 5'(r) && issue_ready;
    assign dec = dataW.regwrite && dataW.dst == 5'(r);
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (reset),
      .inc (inc),
      .dec (dec),
      .cnt (cnt[r]),
      .sat (sat[r])
    );
  end
  // read ports; a forwarded writeback also retires its writer from the busy view
  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (ra1 == 5'(r)) begin
        rd1   = byp1 ? dataW.regdata : regs_q[r];
        busy1 = cnt[r] != CNT_W'(byp1);
      end
      if (ra2 == 5'(r)) begin
        rd2   = byp2 ? dataW.regdata : regs_q[r];
        busy2 = cnt[r] != CNT_W'(byp2);
      end
    end
    if (reset) begin
      rd1   = '0;
      rd2   = '0;
      busy1 = 1'b0;
      busy2 = 1'b0;
    end
  end
  // hold off decode only when the destination counter has no headroom
  always_comb begin
    issue_ready = 1'b1;
    for (int r = 1; r < NREG; r++)
      if (issue_regwrite && issue_dst == 5'(r) && sat[r]) issue_ready = 1'b0;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors against an array/count model of regfile_sb
module tb_regfile_sb;
  import pipes::*;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXC = 3;
  logic clk = 1'b0, reset = 1'b0;
  writeback_data_t dataW;
  logic [4:0]  ra1, ra2, issue_dst;
  logic [63:0] rd1, rd2;
  logic busy1, busy2, issue_valid, issue_regwrite, issue_ready;
  int vectors = 0, miscompares = 0;
  logic [63:0] mreg [32] = '{default: '0};
  int          mcnt [32] = '{default: 0};

  regfile_sb dut (
    .clk(clk), .reset(reset), .dataW(dataW), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
    .issue_dst(issue_dst), .issue_ready(issue_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] a);
    return BYP && dataW.regwrite && a != 0 && dataW.dst == a;
  endfunction
  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (reset || a == 0) return '0;
    return hit(a) ? dataW.regdata : mreg[a];
  endfunction
  function automatic bit exp_busy(input logic [4:0] a);
    if (reset || a == 0) return 1'b0;
    return (mcnt[a] - int'(hit(a))) > 0;
  endfunction
  function automatic bit exp_ready();
    return reset || !issue_regwrite || issue_dst == 0 || mcnt[issue_dst] < MAXC;
  endfunction

  // model: writers counted per register, values stored on writeback
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        mreg[r] <= '0;
        mcnt[r] <= 0;
      end
    end else begin
      automatic bit up = issue_valid && issue_regwrite && issue_dst != 0 && mcnt[issue_dst] < MAXC;
      automatic bit dn = dataW.regwrite && dataW.dst != 0;
      for (int r = 1; r < 32; r++) begin
        automatic int n = mcnt[r] + ((up && issue_dst == r) ? 1 : 0) - ((dn && dataW.dst == r) ? 1 : 0);
        mcnt[r] <= (n < 0) ? 0 : n;
        if (dn && dataW.dst == r) mreg[r] <= dataW.regdata;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("busy1", 64'(busy1), 64'(exp_busy(ra1)));
    chk("busy2", 64'(busy2), 64'(exp_busy(ra2)));
    chk("issue_ready", 64'(issue_ready), 64'(exp_ready()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic iss(input logic v, input logic rw, input logic [4:0] d);
    issue_valid = v;
    issue_regwrite = rw;
    issue_dst = d;
  endtask
  task automatic wb(input logic rw, input logic [4:0] d, input logic [63:0] v);
    dataW.regwrite = rw;
    dataW.dst = d;
    dataW.regdata = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // directed stimulus with hand-computed expectations
  initial begin
    wb(0, 0, 0);
    iss(0, 0, 0);
    ra1 = 0;
    ra2 = 0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ra1 = 5;
    #1;
    chk("reset_rd1", rd1, 0);
    chk("reset_busy1", 64'(busy1), 0);
    chk("reset_rd_x0", rd2, 0);
    chk("reset_ready", 64'(issue_ready), 1);
    tick();
    iss(1, 1, 5);
    #1 chk("issue_not_busy_same_cycle", 64'(busy1), 0);
    tick();
    iss(0, 0, 0);
    #1 chk("busy_after_issue", 64'(busy1), 1);
    tick();
    wb(1, 5, 64'hDEAD_BEEF);
    #1;
    chk("wb_cycle_rd1", rd1, BYP ? 64'hDEAD_BEEF : 64'h0);
    chk("wb_cycle_busy1", 64'(busy1), BYP ? 64'h0 : 64'h1);
    tick();
    wb(0, 0, 0);
    #1;
    chk("after_wb_rd1", rd1, 64'hDEAD_BEEF);
    chk("after_wb_busy1", 64'(busy1), 0);
    tick();
    ra1 = 0;
    ra2 = 5;
    wb(1, 0, 64'h1234);
    #1 chk("x0_wb_same_cycle", rd1, 0);
    tick();
    wb(0, 0, 0);
    #1;
    chk("x0_wb_after", rd1, 0);
    chk("x0_wb_no_side_effect", rd2, 64'hDEAD_BEEF);
    tick();
    ra1 = 7;
    for (int i = 0; i < 3; i++) begin
      iss(1, 1, 7);
      #1 chk("x7_ready_fill", 64'(issue_ready), 1);
      tick();
    end
    iss(1, 1, 7);
    #1;
    chk("x7_ready_4th", 64'(issue_ready), 0);
    chk("x7_busy", 64'(busy1), 1);
    tick();
    iss(0, 1, 7);
    wb(1, 7, 64'h77);
    #1;
    chk("x7_still_full", 64'(issue_ready), 0);
    chk("x7_busy_wb", 64'(busy1), 1);
    tick();
    iss(1, 1, 7);
    wb(1, 7, 64'h78);
    #1 chk("x7_ready_at_2", 64'(issue_ready), 1);
    tick();
    wb(0, 0, 0);
    #1 chk("x7_ready_still_2", 64'(issue_ready), 1);
    tick();
    iss(0, 1, 7);
    #1;
    chk("x7_full_again", 64'(issue_ready), 0);
    chk("x7_data", rd1, 64'h78);
    tick();
    iss(0, 0, 0);
    ra2 = 9;
    iss(1, 1, 9);
    #1 chk("x9_issue", 64'(busy2), 0);
    tick();
    wb(1, 9, 64'h99);
    #1;
    chk("x9_pair_busy", 64'(busy2), BYP ? 64'h0 : 64'h1);
    chk("x9_pair_rd", rd2, BYP ? 64'h99 : 64'h0);
    tick();
    iss(0, 0, 0);
    wb(0, 0, 0);
    #1;
    chk("x9_busy_after_pair", 64'(busy2), 1);
    chk("x9_rd_after_pair", rd2, 64'h99);
    tick();
    ra1 = 3;
    iss(1, 1, 3);
    tick();
    tick();
    wb(1, 3, 64'h55);
    tick();
    iss(0, 1, 3);
    wb(0, 0, 0);
    #1;
    chk("x3_before_reset_rd", rd1, 64'h55);
    chk("x3_before_reset_busy", 64'(busy1), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_rd", rd1, 0);
    chk("async_reset_busy", 64'(busy1), 0);
    chk("async_reset_ready", 64'(issue_ready), 1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("post_reset_rd", rd1, 0);
    chk("post_reset_busy", 64'(busy1), 0);
    chk("post_reset_ready", 64'(issue_ready), 1);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
